regfile_writeback_queue: RTL and testbench

REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

---
 rtl/regfile_writeback_queue.sv | 142 ++++++++++++++
 tb/tb_regfile_writeback_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//
// Purpose: small in-order queue that sits between a result producer and the
// register-file write port. Results are accepted when there is room, retired
// one per cycle to the write port whenever the port is not stalled, and the
// queued (not yet written) values can be probed by two read-port indices so
// that readers can bypass the register file.
//
// Optional feature: define the macro WBQ_BYPASS_EN to compile in the
// hit/forward logic. Without it hit_a/hit_b/fwd_a/fwd_b are tied to 0.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready producer handshake; in_rd/in_data the offered result
//   wr_stall          write port unavailable; holds the head entry
//   RegWr, Rw, busW   register-file write enable / index / data
//   Ra, Rb            read indices probed against queued writes
//   hit_a/b, fwd_a/b  probe hit flags and youngest matching queued value
//   count             number of valid queued entries (0..DEPTH)

module regfile_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_WIDTH-1:0]     in_rd,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      wr_stall,
    output logic                      RegWr,
    output logic [ADDR_WIDTH-1:0]     Rw,
    output logic [DATA_WIDTH-1:0]     busW,
    input  logic [ADDR_WIDTH-1:0]     Ra,
    input  logic [ADDR_WIDTH-1:0]     Rb,
    output logic                      hit_a,
    output logic                      hit_b,
    output logic [DATA_WIDTH-1:0]     fwd_a,
    output logic [DATA_WIDTH-1:0]     fwd_b,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage: written only on enqueue, never reset (validity is
    // tracked by head/count alone).
    logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          ready_q;   // low in reset, high from the first edge after

    logic accept;
    logic enq;
    logic drain;
    logic not_empty;

    assign not_empty = (cnt != '0);

    // in_ready depends only on registered state, never on wr_stall/in_valid,
    // so a full queue cannot be refilled in the same cycle it drains.
    assign in_ready = ready_q & (cnt < CW'(DEPTH));
    assign accept   = in_valid & in_ready;
    // Writes to register 0 are swallowed: handshake completes, nothing queued.
    assign enq      = accept & (in_rd != '0);
    assign drain    = not_empty & ~wr_stall;

    assign RegWr = drain;
    assign Rw    = not_empty ? rd_mem[head]   : '0;
    assign busW  = not_empty ? data_mem[head] : '0;
    assign count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            case ({enq, drain})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[tail]   <= in_rd;
            data_mem[tail] <= in_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    // Scan from oldest (head) to youngest; a later match overwrites an
    // earlier one, so the forwarded value is the youngest queued write.
    logic [PW-1:0] idx;

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        fwd_a = '0;
        fwd_b = '0;
        idx   = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < cnt) begin
                if ((Ra != '0) && (rd_mem[idx] == Ra)) begin
                    hit_a = 1'b1;
                    fwd_a = data_mem[idx];
                end
                if ((Rb != '0) && (rd_mem[idx] == Rb)) begin
                    hit_b = 1'b1;
                    fwd_b = data_mem[idx];
                end
            end
        end
    end
`else
    logic unused_probe;

    assign unused_probe = ^{Ra, Rb};
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
    assign fwd_a = '0;
    assign fwd_b = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          wr_stall;
    logic          RegWr;
    logic [AW-1:0] Rw;
    logic [DW-1:0] busW;
    logic [AW-1:0] Ra;
    logic [AW-1:0] Rb;
    logic          hit_a;
    logic          hit_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic [2:0]    count;

    int checks;
    int errors;

    regfile_writeback_queue #(
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .wr_stall(wr_stall),
        .RegWr(RegWr), .Rw(Rw), .busW(busW), .Ra(Ra), .Rb(Rb),
        .hit_a(hit_a), .hit_b(hit_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
        wr_stall = 1'b0; Ra = '0; Rb = '0;
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL reset_regwr: got %b want 0", RegWr); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (Rw !== 5'd0 || busW !== 32'd0) begin errors++; $display("FAIL reset_rw_busw: got %0d/%h want 0/0", Rw, busW); end
        checks++; if (hit_a !== 1'b0 || fwd_a !== 32'd0) begin errors++; $display("FAIL reset_bypass: got %b/%h want 0/0", hit_a, fwd_a); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_before_edge: got %b want 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after_edge: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        wr_stall = 1'b0; in_valid = 1'b1; in_rd = 5'd3; in_data = 32'hDEADBEEF;
        #1;
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL single_no_early_write: got %b want 0", RegWr); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (RegWr !== 1'b1) begin errors++; $display("FAIL single_regwr: got %b want 1", RegWr); end
        checks++; if (Rw !== 5'd3) begin errors++; $display("FAIL single_rw: got %0d want 3", Rw); end
        checks++; if (busW !== 32'hDEADBEEF) begin errors++; $display("FAIL single_busw: got %h want deadbeef", busW); end
        tick();
        checks++; if (count !== 3'd0 || RegWr !== 1'b0) begin errors++; $display("FAIL single_drained: got count=%0d regwr=%b want 0/0", count, RegWr); end
        checks++; if (Rw !== 5'd0 || busW !== 32'd0) begin errors++; $display("FAIL single_empty_bus: got %0d/%h want 0/0", Rw, busW); end
    endtask

    task automatic test_stall_order();
        logic [2:0] exp_cnt [5];
        exp_cnt[0] = 3'd4; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd3;
        exp_cnt[3] = 3'd2; exp_cnt[4] = 3'd1;
        wr_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_rd = AW'(k); in_data = DW'(k * 32'h11);
            tick();
        end
        in_rd = 5'd5; in_data = 32'h55;
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL stall_count_full: got %0d want 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_full: got %b want 0", in_ready); end
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL stall_regwr: got %b want 0", RegWr); end
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL stall_fifth_held: got %0d want 4", count); end
        wr_stall = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            if (j == 3) in_valid = 1'b0;
            #1;
            checks++; if (RegWr !== 1'b1 || Rw !== AW'(j) || busW !== DW'(j * 32'h11)) begin
                errors++; $display("FAIL stall_order_%0d: got regwr=%b rw=%0d busw=%h want 1/%0d/%h", j, RegWr, Rw, busW, j, j * 32'h11);
            end
            checks++; if (count !== exp_cnt[j-1]) begin errors++; $display("FAIL stall_count_%0d: got %0d want %0d", j, count, exp_cnt[j-1]); end
            if (j == 1) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_drain_no_refill: got %b want 0", in_ready); end
            end
            if (j == 2) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL refill_next_cycle: got %b want 1", in_ready); end
            end
            tick();
        end
        checks++; if (count !== 3'd0 || RegWr !== 1'b0) begin errors++; $display("FAIL stall_drained: got %0d/%b want 0/0", count, RegWr); end
    endtask

    task automatic test_bypass();
        wr_stall = 1'b1;
        in_valid = 1'b1; in_rd = 5'd7; in_data = 32'h100;
        tick();
        in_data = 32'h200;
        tick();
        in_valid = 1'b0; Ra = 5'd7; Rb = 5'd0;
        #1;
        checks++; if (hit_a !== BYP) begin errors++; $display("FAIL bypass_hit_a: got %b want %b", hit_a, BYP); end
        checks++; if (fwd_a !== (BYP ? 32'h200 : 32'h0)) begin errors++; $display("FAIL bypass_fwd_a: got %h want %h", fwd_a, BYP ? 32'h200 : 32'h0); end
        checks++; if (hit_b !== 1'b0 || fwd_b !== 32'd0) begin errors++; $display("FAIL bypass_rb_zero: got %b/%h want 0/0", hit_b, fwd_b); end
        Ra = 5'd6; Rb = 5'd7;
        #1;
        checks++; if (hit_a !== 1'b0 || fwd_a !== 32'd0) begin errors++; $display("FAIL bypass_miss: got %b/%h want 0/0", hit_a, fwd_a); end
        checks++; if (hit_b !== BYP || fwd_b !== (BYP ? 32'h200 : 32'h0)) begin errors++; $display("FAIL bypass_hit_b: got %b/%h want %b", hit_b, fwd_b, BYP); end
        // The value on the input this cycle is not forwarded.
        in_valid = 1'b1; in_rd = 5'd9; in_data = 32'h999; Ra = 5'd9;
        #1;
        checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL bypass_no_input_fwd: got %b want 0", hit_a); end
        tick();
        in_valid = 1'b0; wr_stall = 1'b0; Ra = '0; Rb = '0;
        for (int k = 0; k < 3; k++) tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_drain: got %0d want 0", count); end
    endtask

    task automatic test_rd_zero();
        wr_stall = 1'b0; in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFFFFFFFF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || RegWr !== 1'b0) begin errors++; $display("FAIL rd0_discard: got %0d/%b want 0/0", count, RegWr); end
        tick();
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL rd0_no_write: got %b want 0", RegWr); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] prev_rd;
        logic [DW-1:0] prev_data;
        wr_stall = 1'b0;
        prev_rd = '0; prev_data = '0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_rd = AW'((i % 31) + 1); in_data = 32'h1000 + DW'(i);
            #1;
            if (i > 0) begin
                checks++; if (count !== 3'd1 || RegWr !== 1'b1 || Rw !== prev_rd || busW !== prev_data) begin
                    errors++; $display("FAIL b2b_%0d: got cnt=%0d wr=%b rw=%0d busw=%h want 1/1/%0d/%h", i, count, RegWr, Rw, busW, prev_rd, prev_data);
                end
            end
            prev_rd = in_rd; prev_data = in_data;
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (RegWr !== 1'b1 || Rw !== prev_rd || busW !== prev_data) begin
            errors++; $display("FAIL b2b_last: got wr=%b rw=%0d busw=%h want 1/%0d/%h", RegWr, Rw, busW, prev_rd, prev_data);
        end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        wr_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_rd = AW'(4 + k); in_data = 32'hA0 + DW'(k);
            tick();
        end
        in_valid = 1'b0; Ra = 5'd4; wr_stall = 1'b0;
        #1;
        checks++; if (count !== 3'd3 || RegWr !== 1'b1) begin errors++; $display("FAIL mid_pre: got %0d/%b want 3/1", count, RegWr); end
        checks++; if (hit_a !== BYP) begin errors++; $display("FAIL mid_pre_hit: got %b want %b", hit_a, BYP); end
        rst_n = 1'b0;
        #1;
        checks++; if (RegWr !== 1'b0 || count !== 3'd0 || hit_a !== 1'b0) begin
            errors++; $display("FAIL mid_reset_async: got wr=%b cnt=%0d hit=%b want 0/0/0", RegWr, count, hit_a);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (RegWr !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL mid_no_write_%0d: got %b/%0d want 0/0", k, RegWr, count); end
            tick();
        end
        Ra = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_stall_order();
        test_bypass();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
